rtsnoc_port_arbiter: RTL and testbench
======================================

Name: rtsnoc_port_arbiter

Overview:
Shares one RTSNoC router local port among N_REQ sub-IPs behind it.
- TX side: round-robin arbitration of requester flits onto the router write interface (din_o/wr_o/wait_i).
- RX side: demultiplexes flits from the router read interface (dout_i/nd_i/rd_o) to the requester named by a sub-address held in the MSBs of the flit data field.
- Sits between the router's local port and a cluster of small masters (echo, UART bridge, counters) that would otherwise each need a router port.

Parameters:
SOC_SIZE_X, 1, log2 of mesh X dimension (coordinate field width)
SOC_SIZE_Y, 1, log2 of mesh Y dimension
NOC_DATA_WIDTH, 16, flit data field width
SUBADDR_W, 2, sub-address width; N_REQ = 2**SUBADDR_W requesters
RX_TIMEOUT, 255, cycles an RX offer may stay unacknowledged (used only with optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
din_o  out  38  flit to router; low NOC_BUS_SIZE bits used, rest 0
wr_o  out  1  one-cycle write strobe to router
wait_i  in  1  router cannot accept a write
dout_i  in  38  flit from router
nd_i  in  1  router has a flit pending
rd_o  out  1  one-cycle pop strobe to router
req_din_i  in  N_REQ*38  TX flit per requester; slice k = bits [38k+37:38k]
req_valid_i  in  N_REQ  requester k has a TX flit
req_ack_o  out  N_REQ  one-cycle pulse: flit k captured
rx_dout_o  out  38  RX flit, shared by all requesters
rx_valid_o  out  N_REQ  one-hot: RX flit offered to requester k
rx_ack_i  in  N_REQ  requester k consumes offered flit
drop_cnt_o  out  16  RX flits discarded by timeout

Behaviour:
- Interface (already decided): one clock, clk_i. rst_i is asynchronous, active-high.
- Reset values: din_o=0, wr_o=0, rd_o=0, req_ack_o=0, rx_dout_o=0, rx_valid_o=0, drop_cnt_o=0, rr_ptr=0, both FSMs idle.
- Reset mid-transfer abandons the flit without wr_o or rd_o.
- Flit layout: NOC_BUS_SIZE = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6.
  - Layout MSB to LSB: {X_orig, Y_orig, local_orig[2:0], X_dst, Y_dst, local_dst[2:0], data}.
  - Sub-address = data[NOC_DATA_WIDTH-1 -: SUBADDR_W].
  - TX flits pass through unmodified.
- TX FSM: T_IDLE -> T_WAIT -> T_WRITE -> T_IDLE.
  - T_IDLE, any req_valid_i set: grant k = first set bit searching upward from rr_ptr, wrapping.
    - Latch slice k into din_o.
    - req_ack_o[k]=1 for exactly one cycle.
    - Go to T_WAIT.
  - T_WAIT: req_ack_o=0. While wait_i=1, stay. When wait_i=0: wr_o<=1, go to T_WRITE.
  - T_WRITE: wr_o<=0; rr_ptr <= (k+1) mod N_REQ; go to T_IDLE.
  - Minimum 3 cycles per flit.
  - A requester must update or drop req_valid_i the cycle after its ack.
  - din_o is stable from capture until the cycle after wr_o.
- RX FSM: R_IDLE -> R_OFFER -> R_POP -> R_SETTLE -> R_IDLE.
  - R_IDLE, nd_i=1: rx_dout_o <= dout_i; sel = sub-address; rx_valid_o <= one-hot(sel); go to R_OFFER.
  - R_OFFER: rx_ack_i[sel]=1 -> rx_valid_o<=0, rd_o<=1, go to R_POP. rx_ack_i bits other than sel are ignored.
  - R_POP: rd_o<=0, go to R_SETTLE.
  - R_SETTLE: one dead cycle so nd_i reflects the post-pop router state; then go to R_IDLE.
  - rx_dout_o holds its value until the next capture.
- TX and RX FSMs are fully independent. Simultaneous wr_o and rd_o is legal.
- A requester may hold req_valid_i while being offered RX; no deadlock coupling between the two sides.
- Fairness: each continuously-valid requester is granted within N_REQ grants.

Optional Feature:
- Macro RTSNOC_ARB_RX_TIMEOUT_EN defined:
  - A counter runs in R_OFFER and resets on entry.
  - If RX_TIMEOUT cycles pass without rx_ack_i[sel]: rx_valid_o<=0, rd_o<=1, go to R_POP (flit discarded).
  - drop_cnt_o increments by 1, saturating at 16'hFFFF.
  - Ack and timeout on the same cycle count as an ack, not a drop.
- Macro undefined:
  - R_OFFER waits indefinitely.
  - drop_cnt_o is tied to 0 and no counter logic is generated.

Test Plan:
1. Reset mid T_WAIT (wait_i=1, rst_i pulse) -> wr_o, rd_o, req_ack_o, rx_valid_o all 0 immediately; rr_ptr=0; no write follows.
2. req_valid_i=4'b1111 held, wait_i=0 -> ack order 0,1,2,3,0; wr_o period 3 cycles; each din_o equals the granted slice.
3. req_valid_i=4'b0100, wait_i=1 for 10 cycles -> req_ack_o[2] pulses once; wr_o stays 0 until 1 cycle after wait_i falls; din_o stable throughout.
4. Router flit with data=16'hC0DE (sub-address 3), nd_i=1 -> rx_valid_o=4'b1000, rx_dout_o=flit; rx_ack_i[3] after 5 cycles -> rd_o single pulse the next cycle; no re-offer before R_SETTLE completes.
5. Flit with data=16'h4000 (sub-address 1) offered while requester 0 is being granted on TX -> TX write and RX pop both complete, with no interference in cycle counts.
6. RTSNOC_ARB_RX_TIMEOUT_EN, RX_TIMEOUT=8, never ack -> rd_o pulses 8 cycles after offer; drop_cnt_o=1; an ack on cycle 8 instead -> drop_cnt_o stays 0.

Source files
------------

// File: rtl/rtsnoc_port_arbiter.sv
// Shares one RTSNoC router local port among 2**SUBADDR_W sub-IPs: round-robin TX, sub-address RX demux.
// Optional RX offer timeout and drop counter: define RTSNOC_ARB_RX_TIMEOUT_EN.
module rtsnoc_port_arbiter #(
  parameter int SOC_SIZE_X     = 1,
  parameter int SOC_SIZE_Y     = 1,
  parameter int NOC_DATA_WIDTH = 16,
  parameter int SUBADDR_W      = 2,
  parameter int RX_TIMEOUT     = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  output logic [37:0]                     din_o,
  output logic                            wr_o,
  input  logic                            wait_i,
  input  logic [37:0]                     dout_i,
  input  logic                            nd_i,
  output logic                            rd_o,
  input  logic [(2**SUBADDR_W)*38-1:0]    req_din_i,
  input  logic [(2**SUBADDR_W)-1:0]       req_valid_i,
  output logic [(2**SUBADDR_W)-1:0]       req_ack_o,
  output logic [37:0]                     rx_dout_o,
  output logic [(2**SUBADDR_W)-1:0]       rx_valid_o,
  input  logic [(2**SUBADDR_W)-1:0]       rx_ack_i,
  output logic [15:0]                     drop_cnt_o
);

  localparam int N_REQ       = 2**SUBADDR_W;
  localparam int FLIT_W      = 38;
  localparam int NOC_BUS_SIZE = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6;
  localparam logic [FLIT_W-1:0] BUS_MASK = (FLIT_W'(1) << NOC_BUS_SIZE) - FLIT_W'(1);

  if (RX_TIMEOUT < 1 || NOC_BUS_SIZE > FLIT_W || SUBADDR_W > NOC_DATA_WIDTH) begin : g_param_check
    $error("rtsnoc_port_arbiter: invalid parameterisation");
  end

  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_WRITE} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_OFFER, R_POP, R_SETTLE} rx_state_e;

  tx_state_e               tx_state_q, tx_state_d;
  logic [FLIT_W-1:0]       din_q, din_d;
  logic                    wr_q, wr_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic [SUBADDR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SUBADDR_W-1:0]    gnt_q, gnt_d;

  rx_state_e               rx_state_q, rx_state_d;
  logic [FLIT_W-1:0]       rx_dout_q, rx_dout_d;
  logic [N_REQ-1:0]        rx_valid_q, rx_valid_d;
  logic                    rd_q, rd_d;
  logic [SUBADDR_W-1:0]    sel_q, sel_d;

  logic [FLIT_W-1:0]       req_flit [N_REQ];
  logic [SUBADDR_W-1:0]    rot_idx  [N_REQ];
  logic [N_REQ-1:0]        rot_valid;
  logic [SUBADDR_W-1:0]    grant_idx;
  logic                    rx_hit;
  logic                    rx_expire;

  // Requesters viewed in priority order starting at rr_ptr; index arithmetic wraps mod N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_flit[gi]  = req_din_i[FLIT_W*gi +: FLIT_W] & BUS_MASK;
    assign rot_idx[gi]   = rr_ptr_q + SUBADDR_W'(gi);
    assign rot_valid[gi] = req_valid_i[rot_idx[gi]];
  end

  always_comb begin
    grant_idx = rr_ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) grant_idx = rot_idx[i];
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    din_d      = din_q;
    wr_d       = 1'b0;
    ack_d      = '0;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    case (tx_state_q)
      T_IDLE: begin
        if (|req_valid_i) begin
          din_d      = req_flit[grant_idx];
          ack_d      = N_REQ'(1) << grant_idx;
          gnt_d      = grant_idx;
          tx_state_d = T_WAIT;
        end
      end
      T_WAIT: begin
        if (!wait_i) begin
          wr_d       = 1'b1;
          tx_state_d = T_WRITE;
        end
      end
      T_WRITE: begin
        rr_ptr_d   = gnt_q + 1'b1;
        tx_state_d = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= T_IDLE;
      din_q      <= '0;
      wr_q       <= 1'b0;
      ack_q      <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      din_q      <= din_d;
      wr_q       <= wr_d;
      ack_q      <= ack_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
    end
  end

  assign rx_hit = rx_ack_i[sel_q];

`ifdef RTSNOC_ARB_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(RX_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]      drop_q, drop_d;

  // An ack arriving on the expiry cycle wins, so the flit is delivered rather than dropped.
  assign rx_expire = (rx_state_q == R_OFFER) && !rx_hit && (tmo_q == TMO_W'(RX_TIMEOUT - 1));

  always_comb begin
    tmo_d  = tmo_q;
    drop_d = drop_q;
    if (rx_state_q == R_IDLE) begin
      tmo_d = '0;
    end else if (rx_state_q == R_OFFER && !rx_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (rx_expire && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q  <= '0;
      drop_q <= '0;
    end else begin
      tmo_q  <= tmo_d;
      drop_q <= drop_d;
    end
  end

  assign drop_cnt_o = drop_q;
`else
  assign rx_expire  = 1'b0;
  assign drop_cnt_o = '0;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_dout_d  = rx_dout_q;
    rx_valid_d = rx_valid_q;
    rd_d       = 1'b0;
    sel_d      = sel_q;
    case (rx_state_q)
      R_IDLE: begin
        if (nd_i) begin
          rx_dout_d  = dout_i;
          sel_d      = dout_i[NOC_DATA_WIDTH-1 -: SUBADDR_W];
          rx_valid_d = N_REQ'(1) << dout_i[NOC_DATA_WIDTH-1 -: SUBADDR_W];
          rx_state_d = R_OFFER;
        end
      end
      R_OFFER: begin
        if (rx_hit || rx_expire) begin
          rx_valid_d = '0;
          rd_d       = 1'b1;
          rx_state_d = R_POP;
        end
      end
      R_POP:    rx_state_d = R_SETTLE;
      // Extra cycle lets nd_i reflect the router state after the pop.
      R_SETTLE: rx_state_d = R_IDLE;
      default:  rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q <= R_IDLE;
      rx_dout_q  <= '0;
      rx_valid_q <= '0;
      rd_q       <= 1'b0;
      sel_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_dout_q  <= rx_dout_d;
      rx_valid_q <= rx_valid_d;
      rd_q       <= rd_d;
      sel_q      <= sel_d;
    end
  end

  assign din_o      = din_q;
  assign wr_o       = wr_q;
  assign req_ack_o  = ack_q;
  assign rx_dout_o  = rx_dout_q;
  assign rx_valid_o = rx_valid_q;
  assign rd_o       = rd_q;

endmodule

// File: tb/tb_rtsnoc_port_arbiter.sv
// Directed testbench for rtsnoc_port_arbiter (4 requesters, 26-bit flits, RX_TIMEOUT=8).
module tb_rtsnoc_port_arbiter;

  logic         clk_i;
  logic         rst_i;
  logic [37:0]  din_o;
  logic         wr_o;
  logic         wait_i;
  logic [37:0]  dout_i;
  logic         nd_i;
  logic         rd_o;
  logic [151:0] req_din_i;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_ack_o;
  logic [37:0]  rx_dout_o;
  logic [3:0]   rx_valid_o;
  logic [3:0]   rx_ack_i;
  logic [15:0]  drop_cnt_o;

  int checks;
  int failures;
  logic [37:0] slice_val [4];
  logic [37:0] exp_din [4];
  logic [37:0] bus_mask;

  rtsnoc_port_arbiter #(
    .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .NOC_DATA_WIDTH(16), .SUBADDR_W(2), .RX_TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .din_o(din_o), .wr_o(wr_o), .wait_i(wait_i),
    .dout_i(dout_i), .nd_i(nd_i), .rd_o(rd_o), .req_din_i(req_din_i),
    .req_valid_i(req_valid_i), .req_ack_o(req_ack_o), .rx_dout_o(rx_dout_o),
    .rx_valid_o(rx_valid_o), .rx_ack_i(rx_ack_i), .drop_cnt_o(drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0; wait_i = 1'b0; nd_i = 1'b0; dout_i = '0; rx_ack_i = '0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b1;
    step();
    checks++; if (din_o !== 38'h0) begin failures++; $display("FAIL reset_din: got %h want 0", din_o); end
    checks++; if (wr_o !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b want 0", wr_o); end
    checks++; if (rd_o !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b want 0", rd_o); end
    checks++; if (req_ack_o !== 4'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", req_ack_o); end
    checks++; if (rx_dout_o !== 38'h0) begin failures++; $display("FAIL reset_rx_dout: got %h want 0", rx_dout_o); end
    checks++; if (rx_valid_o !== 4'b0) begin failures++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid_o); end
    checks++; if (drop_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_drop: got %h want 0", drop_cnt_o); end
    rst_i = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_reset_mid_wait();
    logic [37:0] f;
    do_reset();
    // full transfer for requester 2 leaves rr_ptr at 3
    req_valid_i = 4'b0100;
    step();
    checks++; if (req_ack_o !== 4'b0100) begin failures++; $display("FAIL midrst_first_ack: got %b want 0100", req_ack_o); end
    req_valid_i = '0;
    step();
    step();
    // second grant parked in T_WAIT, plus an RX offer in flight
    f = 38'({1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b100, 16'h1234});
    req_valid_i = 4'b1000; wait_i = 1'b1; nd_i = 1'b1; dout_i = f;
    step();
    checks++; if (req_ack_o !== 4'b1000) begin failures++; $display("FAIL midrst_second_ack: got %b want 1000", req_ack_o); end
    checks++; if (rx_valid_o !== 4'b0001) begin failures++; $display("FAIL midrst_rx_offer: got %b want 0001", rx_valid_o); end
    req_valid_i = '0;
    step();
    #3 rst_i = 1'b1;
    #1;
    checks++; if (wr_o !== 1'b0) begin failures++; $display("FAIL midrst_wr: got %b want 0", wr_o); end
    checks++; if (rd_o !== 1'b0) begin failures++; $display("FAIL midrst_rd: got %b want 0", rd_o); end
    checks++; if (req_ack_o !== 4'b0) begin failures++; $display("FAIL midrst_ack: got %b want 0", req_ack_o); end
    checks++; if (rx_valid_o !== 4'b0) begin failures++; $display("FAIL midrst_rx_valid: got %b want 0", rx_valid_o); end
    checks++; if (din_o !== 38'h0) begin failures++; $display("FAIL midrst_din: got %h want 0", din_o); end
    step();
    rst_i = 1'b0; wait_i = 1'b0; nd_i = 1'b0; dout_i = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (wr_o !== 1'b0 || rd_o !== 1'b0) begin failures++; $display("FAIL midrst_no_write: cycle %0d wr=%b rd=%b want 0 0", i, wr_o, rd_o); end
    end
    // rr_ptr back at 0: requester 0 beats requester 3
    req_valid_i = 4'b1001;
    step();
    checks++; if (req_ack_o !== 4'b0001) begin failures++; $display("FAIL midrst_rr_ptr: got ack %b want 0001", req_ack_o); end
    req_valid_i = '0;
    step();
    step();
    $display("reset_mid_wait: done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    int k;
    do_reset();
    req_valid_i = 4'b1111; wait_i = 1'b0;
    for (int g = 0; g < 5; g++) begin
      k = g % 4;
      exp_ack = 4'b0001 << k;
      step();
      checks++; if (req_ack_o !== exp_ack || wr_o !== 1'b0) begin failures++; $display("FAIL rr_grant%0d: ack=%b wr=%b want ack=%b wr=0", g, req_ack_o, wr_o, exp_ack); end
      checks++; if (din_o !== exp_din[k]) begin failures++; $display("FAIL rr_din%0d: got %h want %h", g, din_o, exp_din[k]); end
      step();
      checks++; if (wr_o !== 1'b1 || req_ack_o !== 4'b0 || din_o !== exp_din[k]) begin failures++; $display("FAIL rr_write%0d: wr=%b ack=%b din=%h want 1 0000 %h", g, wr_o, req_ack_o, din_o, exp_din[k]); end
      step();
      checks++; if (wr_o !== 1'b0) begin failures++; $display("FAIL rr_wr_drop%0d: got %b want 0", g, wr_o); end
      $display("round_robin: grant %0d -> requester %0d", g, k);
    end
    req_valid_i = '0;
  endtask

  task automatic test_wait_hold();
    req_valid_i = 4'b0100; wait_i = 1'b1;
    step();
    checks++; if (req_ack_o !== 4'b0100 || din_o !== exp_din[2]) begin failures++; $display("FAIL wait_grant: ack=%b din=%h want 0100 %h", req_ack_o, din_o, exp_din[2]); end
    req_valid_i = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (req_ack_o !== 4'b0 || wr_o !== 1'b0 || din_o !== exp_din[2]) begin failures++; $display("FAIL wait_hold%0d: ack=%b wr=%b din=%h want 0000 0 %h", i, req_ack_o, wr_o, din_o, exp_din[2]); end
    end
    wait_i = 1'b0;
    step();
    checks++; if (wr_o !== 1'b1 || din_o !== exp_din[2]) begin failures++; $display("FAIL wait_release: wr=%b din=%h want 1 %h", wr_o, din_o, exp_din[2]); end
    step();
    checks++; if (wr_o !== 1'b0 || din_o !== exp_din[2]) begin failures++; $display("FAIL wait_after: wr=%b din=%h want 0 %h", wr_o, din_o, exp_din[2]); end
    $display("wait_hold: write after wait release");
  endtask

  task automatic test_rx_offer();
    logic [37:0] f1;
    logic [37:0] f2;
    f1 = 38'({1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 3'b010, 16'hC0DE});
    f2 = 38'({1'b0, 1'b0, 3'b011, 1'b1, 1'b1, 3'b110, 16'h0001});
    nd_i = 1'b1; dout_i = f1;
    step();
    checks++; if (rx_valid_o !== 4'b1000 || rx_dout_o !== f1 || rd_o !== 1'b0) begin failures++; $display("FAIL rx_offer: valid=%b dout=%h rd=%b want 1000 %h 0", rx_valid_o, rx_dout_o, rd_o, f1); end
    rx_ack_i = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rx_valid_o !== 4'b1000 || rd_o !== 1'b0) begin failures++; $display("FAIL rx_hold%0d: valid=%b rd=%b want 1000 0", i, rx_valid_o, rd_o); end
    end
    rx_ack_i = 4'b1000;
    step();
    checks++; if (rx_valid_o !== 4'b0 || rd_o !== 1'b1) begin failures++; $display("FAIL rx_pop: valid=%b rd=%b want 0000 1", rx_valid_o, rd_o); end
    rx_ack_i = '0; dout_i = f2;
    step();
    checks++; if (rd_o !== 1'b0 || rx_valid_o !== 4'b0 || rx_dout_o !== f1) begin failures++; $display("FAIL rx_pop_end: rd=%b valid=%b dout=%h want 0 0000 %h", rd_o, rx_valid_o, rx_dout_o, f1); end
    step();
    checks++; if (rx_valid_o !== 4'b0) begin failures++; $display("FAIL rx_settle: valid=%b want 0000", rx_valid_o); end
    step();
    checks++; if (rx_valid_o !== 4'b0001 || rx_dout_o !== f2) begin failures++; $display("FAIL rx_reoffer: valid=%b dout=%h want 0001 %h", rx_valid_o, rx_dout_o, f2); end
    rx_ack_i = 4'b0001;
    step();
    checks++; if (rd_o !== 1'b1) begin failures++; $display("FAIL rx_pop2: rd=%b want 1", rd_o); end
    rx_ack_i = '0; nd_i = 1'b0;
    step();
    step();
    step();
    $display("rx_offer: two flits delivered");
  endtask

  task automatic test_concurrent();
    logic [37:0] f;
    f = 38'({1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 3'b111, 16'h4000});
    req_valid_i = 4'b0001; wait_i = 1'b0; nd_i = 1'b1; dout_i = f; rx_ack_i = 4'b0010;
    step();
    checks++; if (req_ack_o !== 4'b0001 || din_o !== exp_din[0]) begin failures++; $display("FAIL conc_grant: ack=%b din=%h want 0001 %h", req_ack_o, din_o, exp_din[0]); end
    checks++; if (rx_valid_o !== 4'b0010 || rx_dout_o !== f) begin failures++; $display("FAIL conc_offer: valid=%b dout=%h want 0010 %h", rx_valid_o, rx_dout_o, f); end
    req_valid_i = '0;
    step();
    checks++; if (wr_o !== 1'b1 || rd_o !== 1'b1 || rx_valid_o !== 4'b0) begin failures++; $display("FAIL conc_both: wr=%b rd=%b valid=%b want 1 1 0000", wr_o, rd_o, rx_valid_o); end
    nd_i = 1'b0; rx_ack_i = '0;
    step();
    checks++; if (wr_o !== 1'b0 || rd_o !== 1'b0) begin failures++; $display("FAIL conc_end: wr=%b rd=%b want 0 0", wr_o, rd_o); end
    step();
    step();
    $display("concurrent: tx write and rx pop together");
  endtask

  task automatic test_rx_timeout();
    logic [37:0] f;
    f = 38'({1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 3'b001, 16'h8001});
    nd_i = 1'b1; dout_i = f;
    step();
    checks++; if (rx_valid_o !== 4'b0100) begin failures++; $display("FAIL tmo_offer: valid=%b want 0100", rx_valid_o); end
`ifdef RTSNOC_ARB_RX_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (rd_o !== 1'b0 || rx_valid_o !== 4'b0100 || drop_cnt_o !== 16'd0) begin failures++; $display("FAIL tmo_wait%0d: rd=%b valid=%b drop=%0d want 0 0100 0", i, rd_o, rx_valid_o, drop_cnt_o); end
    end
    step();
    checks++; if (rd_o !== 1'b1 || rx_valid_o !== 4'b0 || drop_cnt_o !== 16'd1) begin failures++; $display("FAIL tmo_fire: rd=%b valid=%b drop=%0d want 1 0000 1", rd_o, rx_valid_o, drop_cnt_o); end
    step();
    step();
    step();
    checks++; if (rx_valid_o !== 4'b0100) begin failures++; $display("FAIL tmo_offer2: valid=%b want 0100", rx_valid_o); end
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (rd_o !== 1'b0) begin failures++; $display("FAIL tmo_wait2_%0d: rd=%b want 0", i, rd_o); end
    end
    rx_ack_i = 4'b0100;
    step();
    checks++; if (rd_o !== 1'b1 || drop_cnt_o !== 16'd1) begin failures++; $display("FAIL tmo_ack_wins: rd=%b drop=%0d want 1 1", rd_o, drop_cnt_o); end
    $display("rx_timeout: one drop, ack on expiry cycle delivered");
`else
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (rd_o !== 1'b0 || rx_valid_o !== 4'b0100) begin failures++; $display("FAIL notmo_wait%0d: rd=%b valid=%b want 0 0100", i, rd_o, rx_valid_o); end
    end
    checks++; if (drop_cnt_o !== 16'd0) begin failures++; $display("FAIL notmo_drop: got %0d want 0", drop_cnt_o); end
    rx_ack_i = 4'b0100;
    step();
    checks++; if (rd_o !== 1'b1) begin failures++; $display("FAIL notmo_pop: rd=%b want 1", rd_o); end
    $display("rx_timeout: offer held indefinitely without timeout");
`endif
    rx_ack_i = '0; nd_i = 1'b0;
    step();
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_i = 1'b1;
    bus_mask = (38'd1 << 26) - 38'd1;
    for (int k = 0; k < 4; k++) slice_val[k] = 38'h0123_4560 + 38'(k) * 38'h0011_1111;
    slice_val[3] = 38'h3F_FC98_7654;
    for (int k = 0; k < 4; k++) begin
      exp_din[k] = slice_val[k] & bus_mask;
      req_din_i[38*k +: 38] = slice_val[k];
    end
    test_reset();
    test_reset_mid_wait();
    test_round_robin();
    test_wait_hold();
    test_rx_offer();
    test_concurrent();
    test_rx_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
